// File: rtl/snake_disp_pkg.sv
// Shared types, segment constants and BCD helpers for the score display slice.
package snake_disp_pkg;

    // Converter FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2
    } conv_state_e;

    // Destination of the conversion in flight
    typedef enum logic {
        TGT_SCORE = 1'b0,
        TGT_BEST  = 1'b1
    } conv_tgt_e;

    localparam int NUM_DIGITS = 6;

    // Active-low segment patterns {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_D0    = 8'hC0;
    localparam logic [7:0] SEG_D1    = 8'hF9;
    localparam logic [7:0] SEG_D2    = 8'hA4;
    localparam logic [7:0] SEG_D3    = 8'hB0;
    localparam logic [7:0] SEG_D4    = 8'h99;
    localparam logic [7:0] SEG_D5    = 8'h92;
    localparam logic [7:0] SEG_D6    = 8'h82;
    localparam logic [7:0] SEG_D7    = 8'hF8;
    localparam logic [7:0] SEG_D8    = 8'h80;
    localparam logic [7:0] SEG_D9    = 8'h90;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 after the shift
    function automatic logic [3:0] add3_ge5(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // One double-dabble iteration on {H,T,U,operand}: correct the nibbles, then shift left
    function automatic logic [19:0] dabble_step(input logic [19:0] w);
        logic [19:0] adj;
        adj = {add3_ge5(w[19:16]), add3_ge5(w[15:12]), add3_ge5(w[11:8]), w[7:0]};
        return {adj[18:0], 1'b0};
    endfunction

    // BCD digit to active-low segments; codes 10..15 cannot occur and are shown blank
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = SEG_D0;
            4'd1:    s = SEG_D1;
            4'd2:    s = SEG_D2;
            4'd3:    s = SEG_D3;
            4'd4:    s = SEG_D4;
            4'd5:    s = SEG_D5;
            4'd6:    s = SEG_D6;
            4'd7:    s = SEG_D7;
            4'd8:    s = SEG_D8;
            4'd9:    s = SEG_D9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Segments for a 3-digit group {H,T,U} with leading-zero blanking; U is always shown
    function automatic logic [23:0] group_segs(input logic [11:0] bcd);
        logic [7:0] sh;
        logic [7:0] st;
        if (bcd[11:8] == 4'd0) begin
            sh = SEG_BLANK;
        end else begin
            sh = seg_decode(bcd[11:8]);
        end
        if ((bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0)) begin
            st = SEG_BLANK;
        end else begin
            st = seg_decode(bcd[7:4]);
        end
        return {sh, st, seg_decode(bcd[3:0])};
    endfunction

endpackage

// File: rtl/score_display_ctrl_bin8_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3, 8 iterations).
module bin8_to_bcd_seq
    import snake_disp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] operand,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd_h,
    output logic [3:0] bcd_t,
    output logic [3:0] bcd_u
);

    conv_state_e state_r;
    logic [2:0]  cnt_r;
    logic [19:0] work_r;
    logic        busy_r;
    logic        done_r;

    // Converter FSM: capture operand, run 8 dabble steps, hold the result for one write cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            work_r  <= 20'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        work_r  <= {12'd0, operand};
                        cnt_r   <= 3'd0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    work_r <= dabble_step(work_r);
                    cnt_r  <= cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        state_r <= ST_WRITE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_SHIFT;
                        done_r  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign bcd_h = work_r[19:16];
    assign bcd_t = work_r[15:12];
    assign bcd_u = work_r[11:8];

endmodule

// File: rtl/score_display_ctrl.sv
// Score/best tracking, BCD conversion arbitration and 6-digit multiplexed 7-segment scan.
module score_display_ctrl
    import snake_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] num,
    input  logic [1:0] game_status,
    output logic [7:0] seg,
    output logic [5:0] sel,
    output logic       busy
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [7:0]       best_q;
    logic [7:0]       score_src_q;
    logic [7:0]       best_src_q;
    logic [11:0]      score_bcd_q;
    logic [11:0]      best_bcd_q;
    conv_tgt_e        tgt_r;
    logic [7:0]       cap_r;
    logic [DIV_W-1:0] div_r;
    logic [2:0]       idx_r;
    logic [7:0]       seg_r;
    logic [5:0]       sel_r;

    logic             start_s;
    logic [7:0]       start_op_s;
    conv_tgt_e        start_tgt_s;
    logic             conv_busy_s;
    logic             conv_done_s;
    logic [3:0]       conv_h_s;
    logic [3:0]       conv_t_s;
    logic [3:0]       conv_u_s;
    logic [23:0]      score_segs_s;
    logic [23:0]      best_segs_s;
    logic [7:0]       cur_seg_s;

    bin8_to_bcd_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .start   (start_s),
        .operand (start_op_s),
        .busy    (conv_busy_s),
        .done    (conv_done_s),
        .bcd_h   (conv_h_s),
        .bcd_t   (conv_t_s),
        .bcd_u   (conv_u_s)
    );

    // Session best: follows any higher score, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            best_q <= 8'd0;
        end else if (num > best_q) begin
            best_q <= num;
        end else begin
            best_q <= best_q;
        end
    end

    // Trigger arbitration while the converter is idle; a stale score wins over a stale best
    always_comb begin
        start_s     = 1'b0;
        start_op_s  = num;
        start_tgt_s = TGT_SCORE;
        if (!conv_busy_s) begin
            if (num != score_src_q) begin
                start_s     = 1'b1;
                start_op_s  = num;
                start_tgt_s = TGT_SCORE;
            end else if (best_q != best_src_q) begin
                start_s     = 1'b1;
                start_op_s  = best_q;
                start_tgt_s = TGT_BEST;
            end else begin
                start_s     = 1'b0;
            end
        end else begin
            start_s = 1'b0;
        end
    end

    // Remember what is being converted and commit the result to the matching BCD register
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_r       <= TGT_SCORE;
            cap_r       <= 8'd0;
            score_bcd_q <= 12'd0;
            best_bcd_q  <= 12'd0;
            score_src_q <= 8'd0;
            best_src_q  <= 8'd0;
        end else begin
            if (start_s) begin
                tgt_r <= start_tgt_s;
                cap_r <= start_op_s;
            end else begin
                tgt_r <= tgt_r;
                cap_r <= cap_r;
            end
            if (conv_done_s) begin
                if (tgt_r == TGT_SCORE) begin
                    score_bcd_q <= {conv_h_s, conv_t_s, conv_u_s};
                    score_src_q <= cap_r;
                end else begin
                    best_bcd_q  <= {conv_h_s, conv_t_s, conv_u_s};
                    best_src_q  <= cap_r;
                end
            end else begin
                score_bcd_q <= score_bcd_q;
                best_bcd_q  <= best_bcd_q;
            end
        end
    end

    // Segment pattern for the digit currently addressed by the scanner
    always_comb begin
        best_segs_s = group_segs(best_bcd_q);
        if (game_status == 2'b00) begin
            score_segs_s = {SEG_DASH, SEG_DASH, SEG_DASH};
        end else begin
            score_segs_s = group_segs(score_bcd_q);
        end
        case (idx_r)
            3'd0:    cur_seg_s = score_segs_s[7:0];
            3'd1:    cur_seg_s = score_segs_s[15:8];
            3'd2:    cur_seg_s = score_segs_s[23:16];
            3'd3:    cur_seg_s = best_segs_s[7:0];
            3'd4:    cur_seg_s = best_segs_s[15:8];
            3'd5:    cur_seg_s = best_segs_s[23:16];
            default: cur_seg_s = SEG_BLANK;
        endcase
    end

    // Scan divider and digit index: advance one digit every SCAN_DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r <= '0;
            idx_r <= 3'd0;
        end else if (div_r == DIV_W'(SCAN_DIV - 1)) begin
            div_r <= '0;
            if (idx_r == 3'(NUM_DIGITS - 1)) begin
                idx_r <= 3'd0;
            end else begin
                idx_r <= idx_r + 3'd1;
            end
        end else begin
            div_r <= div_r + DIV_W'(1);
            idx_r <= idx_r;
        end
    end

    // Pin registers: select and segments come from the same index so they switch together
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= SEG_BLANK;
            sel_r <= 6'b111110;
        end else begin
            seg_r <= cur_seg_s;
            sel_r <= ~(6'b000001 << idx_r);
        end
    end

    assign seg  = seg_r;
    assign sel  = sel_r;
    assign busy = conv_busy_s;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed, table-driven bench for score_display_ctrl (SCAN_DIV = 4).
module tb_score_display_ctrl;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] num = 8'd0;
    logic [1:0] game_status = 2'b01;
    logic [7:0] seg;
    logic [5:0] sel;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_seg [0:5];
    logic [5:0] seen;

    typedef struct {
        logic        do_rst;
        logic [7:0]  num;
        logic [1:0]  gs;
        logic [47:0] exp;   // {d5,d4,d3,d2,d1,d0}
    } vec_t;

    vec_t vecs [0:9];

    score_display_ctrl #(.SCAN_DIV(SD)) dut (
        .clk         (clk),
        .rst         (rst),
        .num         (num),
        .game_status (game_status),
        .seg         (seg),
        .sel         (sel),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Let conversions settle, watch a full scan rotation, compare every digit
    task automatic check_display(input string name, input logic [47:0] exp);
        repeat (30) @(posedge clk);
        seen = 6'b000000;
        for (int i = 0; i < 6; i++) cap_seg[i] = 8'h00;
        for (int c = 0; c < 6 * SD + 4; c++) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                if (sel == ~(6'b000001 << i)) begin
                    cap_seg[i] = seg;
                    seen[i]    = 1'b1;
                end
            end
        end
        chk({name, "_seen"}, {42'd0, seen}, {42'd0, 6'b111111});
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_dig%0d", name, i), {40'd0, cap_seg[i]}, {40'd0, exp[i*8 +: 8]});
        end
    endtask

    initial begin
        int   cnt;
        int   idx;
        logic [5:0] cur;

        vecs[0] = '{1'b1, 8'd0,   2'b01, 48'hFFFFC0FFFFC0};
        vecs[1] = '{1'b0, 8'd255, 2'b01, 48'hA49292A49292};
        vecs[2] = '{1'b0, 8'd7,   2'b01, 48'hA49292FFFFF8};
        vecs[3] = '{1'b0, 8'd100, 2'b00, 48'hA49292BFBFBF};
        vecs[4] = '{1'b1, 8'd42,  2'b01, 48'hFF99A4FF99A4};
        vecs[5] = '{1'b0, 8'd0,   2'b00, 48'hFF99A4BFBFBF};
        vecs[6] = '{1'b0, 8'd9,   2'b10, 48'hFF99A4FFFF90};
        vecs[7] = '{1'b0, 8'd130, 2'b11, 48'hF9B0C0F9B0C0};
        vecs[8] = '{1'b0, 8'd105, 2'b01, 48'hF9B0C0F9C092};
        vecs[9] = '{1'b0, 8'd68,  2'b01, 48'hF9B0C0FF8280};

        // Reset state and first cycle after release
        num = 8'd0; game_status = 2'b01;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_seg",  {40'd0, seg},  {40'd0, 8'hFF});
        chk("rst_sel",  {42'd0, sel},  {42'd0, 6'b111110});
        chk("rst_busy", {47'd0, busy}, 48'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_seg", {40'd0, seg}, {40'd0, 8'hC0});
        chk("post_rst_sel", {42'd0, sel}, {42'd0, 6'b111110});

        // Table-driven display vectors
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].do_rst) begin
                num = vecs[v].num;
                game_status = vecs[v].gs;
                do_reset();
            end else begin
                @(posedge clk);
                #1 num = vecs[v].num;
                game_status = vecs[v].gs;
            end
            check_display($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Latency: 0 -> 255, score conversion then best conversion
        num = 8'd0; game_status = 2'b01;
        do_reset();
        @(posedge clk);
        #1 num = 8'd255;
        for (int k = 0; k <= 21; k++) begin
            @(negedge clk);
            chk($sformatf("lat_busy_k%0d", k), {47'd0, busy},
                {47'd0, ((k >= 1 && k <= 9) || (k >= 11 && k <= 19)) ? 1'b1 : 1'b0});
            if (k == 10) chk("lat_score_bcd", {36'd0, dut.score_bcd_q}, {36'd0, 12'h255});
            if (k == 20) chk("lat_best_bcd",  {36'd0, dut.best_bcd_q},  {36'd0, 12'h255});
        end

        // Input change during SHIFT: stale value completes, then retrigger
        num = 8'd0;
        do_reset();
        @(posedge clk);
        #1 num = 8'd5;
        repeat (3) @(posedge clk);
        #1 num = 8'd6;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("retrig_first_src", {40'd0, dut.score_src_q}, {40'd0, 8'd5});
        chk("retrig_first_bcd", {36'd0, dut.score_bcd_q}, {36'd0, 12'h005});
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("retrig_second_src", {40'd0, dut.score_src_q}, {40'd0, 8'd6});
        chk("retrig_second_bcd", {36'd0, dut.score_bcd_q}, {36'd0, 12'h006});
        check_display("retrig", 48'hFFFF82FFFF82);

        // Scan rotation: sel changes exactly every SD cycles, 0..5 then wraps
        num = 8'd7;
        cur = sel;
        cnt = 0;
        while (sel == cur && cnt < 12) begin
            @(negedge clk);
            cnt++;
        end
        idx = 0;
        for (int i = 0; i < 6; i++) if (sel == ~(6'b000001 << i)) idx = i;
        for (int j = 0; j < 7; j++) begin
            cur = sel;
            cnt = 0;
            while (sel == cur && cnt < 12) begin
                @(negedge clk);
                cnt++;
            end
            idx = (idx + 1) % 6;
            chk($sformatf("scan_period_%0d", j), 48'(cnt), 48'(SD));
            chk($sformatf("scan_sel_%0d", j), {42'd0, sel}, {42'd0, ~(6'b000001 << idx)});
        end

        // Reset during SHIFT aborts; 100 is then converted afresh
        num = 8'd0;
        do_reset();
        @(posedge clk);
        #1 num = 8'd100;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort_pre_busy", {47'd0, busy}, {47'd0, 1'b1});
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_seg",  {40'd0, seg},  {40'd0, 8'hFF});
        chk("abort_sel",  {42'd0, sel},  {42'd0, 6'b111110});
        chk("abort_busy", {47'd0, busy}, 48'd0);
        chk("abort_best", {40'd0, dut.best_q}, 48'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_rel_seg",  {40'd0, seg},  {40'd0, 8'hC0});
        chk("abort_rel_busy", {47'd0, busy}, {47'd0, 1'b1});
        check_display("abort", 48'hF9C0C0F9C0C0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
